// File: rtl/midi_tx.sv
// midi_tx: MIDI OUT serializer. Takes one 1-3 byte MIDI message per
// valid/ready handshake and sends it as back-to-back 8N1 frames, LSB first,
// at CLK_HZ/BAUD clocks per bit. The line idles high.
//
// Optional feature: define MIDI_RUNNING_STATUS_EN to drop a channel status
// byte that repeats the last one sent (MIDI running status).
//
// Timing:
// - midi_out is registered one cycle behind the FSM state. The start bit
//   therefore appears on the first edge after the accepting edge.
// - byte_done marks the final clock of each stop bit.
// - CLK_HZ/BAUD must be at least 4.
module midi_tx #(
    parameter int CLK_HZ = 48_000_000,
    parameter int BAUD   = 31250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic [1:0] msg_len,
    output logic       midi_out,
    output logic       busy,
    output logic       byte_done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_bytes_left;
    logic             r_out;
    logic             r_byte_done;

    // Byte currently on the wire, plus the (up to) two bytes still queued.
    logic [7:0]       r_shift;
    logic [7:0]       r_q0;
    logic [7:0]       r_q1;

    logic             w_idle;
    logic             w_accept;
    logic             w_baud_last;
    logic             w_load_next;
    logic             w_shift_bit;
    logic [1:0]       w_len_eff;
    logic             w_skip;
    logic [7:0]       w_first;
    logic [7:0]       w_second;
    logic [7:0]       w_third;
    logic [1:0]       w_left;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = msg_valid && w_idle;
    assign w_baud_last = (r_baud_cnt == CNT_LAST);
    assign w_load_next = (r_state == S_STOP) && w_baud_last && (r_bytes_left != 2'd0);
    assign w_shift_bit = (r_state == S_DATA) && w_baud_last;

    // A length of 0 is sent as a single status byte.
    assign w_len_eff = (msg_len == 2'd0) ? 2'd1 : msg_len;

`ifdef MIDI_RUNNING_STATUS_EN
    logic       r_rs_valid;
    logic [7:0] r_rs_status;
    logic       w_is_chan;
    logic       w_is_common;

    assign w_is_chan   = (msg_status >= 8'h80) && (msg_status <= 8'hEF);
    assign w_is_common = (msg_status >= 8'hF0) && (msg_status <= 8'hF7);

    // A lone status byte is never suppressed; only status+data messages can ride running status.
    assign w_skip = r_rs_valid && w_is_chan && (msg_status == r_rs_status) && (w_len_eff != 2'd1);

    // Track the last channel status sent; system common cancels it, real-time leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs_valid  <= 1'b0;
            r_rs_status <= 8'h00;
        end else if (w_accept) begin
            if (w_is_chan) begin
                r_rs_valid  <= 1'b1;
                r_rs_status <= msg_status;
            end else if (w_is_common) begin
                r_rs_valid  <= 1'b0;
            end
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // When the status byte is suppressed the data bytes move up one slot.
    assign w_first  = w_skip ? msg_data1 : msg_status;
    assign w_second = w_skip ? msg_data2 : msg_data1;
    assign w_third  = msg_data2;
    assign w_left   = w_len_eff - 2'd1 - {1'b0, w_skip};

    // Frame sequencer: start bit, eight data bits, stop bit, then the next queued byte or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= 3'd0;
            r_bytes_left <= 2'd0;
            r_out        <= 1'b1;
            r_byte_done  <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out      <= 1'b1;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
                    if (w_accept) begin
                        r_bytes_left <= w_left;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_out <= 1'b0;
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    r_out <= r_shift[0];
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_out <= 1'b1;
                    if (w_baud_last) begin
                        r_baud_cnt  <= '0;
                        r_byte_done <= 1'b1;
                        if (r_bytes_left != 2'd0) begin
                            r_bytes_left <= r_bytes_left - 2'd1;
                            r_state      <= S_START;
                        end else begin
                            r_state      <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_out   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte datapath: capture the message at acceptance, shift out bits, advance the byte queue.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift <= w_first;
            r_q0    <= w_second;
            r_q1    <= w_third;
        end else if (w_load_next) begin
            r_shift <= r_q0;
            r_q0    <= r_q1;
        end else if (w_shift_bit) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // Handshake outputs are held inactive during reset; otherwise busy is simply !ready.
    assign msg_ready = reset && w_idle;
    assign busy      = reset && !w_idle;
    assign midi_out  = r_out;
    assign byte_done = r_byte_done;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx at 100 clocks per bit.
// Timing reference:
// - Edge E0 is the edge that accepts a message.
// - Each bit is sampled mid-bit, at E(1000*b + 151 + 100*k).
// - Stop bits are checked at E(1000*b + 951).
// - byte_done is expected to be high just after E(1000*(b+1)).
module tb_midi_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic [1:0] msg_len;
    logic       midi_out;
    logic       busy;
    logic       byte_done;

    int n_assert = 0;
    int n_fail   = 0;

    midi_tx #(
        .CLK_HZ (3_125_000),
        .BAUD   (31250)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_len    (msg_len),
        .midi_out   (midi_out),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a message and wait (bounded) for it to be accepted; returns at E0+1.
    task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [1:0] len);
        int k;
        msg_status = st;
        msg_data1  = d1;
        msg_data2  = d2;
        msg_len    = len;
        msg_valid  = 1'b1;
        k = 0;
        while (!msg_ready && k < 5000) begin
            step(1);
            k++;
        end
        chk("accept_wait", (k < 5000) ? 8'd1 : 8'd0, 8'd1);
        step(1);
    endtask

    // Decode n frames starting from E0+1 and compare them with the expected bytes.
    task automatic frames(input string tag, input int n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp_b [3];
        logic [7:0] got;
        exp_b = '{e0, e1, e2};
        chk({tag, "_busy_at_accept"}, {7'd0, busy}, 8'd1);
        chk({tag, "_ready_at_accept"}, {7'd0, msg_ready}, 8'd0);
        chk({tag, "_line_at_accept"}, {7'd0, midi_out}, 8'd1);
        for (int b = 0; b < n; b++) begin
            step(1);
            chk($sformatf("%s_b%0d_start", tag, b), {7'd0, midi_out}, 8'd0);
            step(50);
            got = 8'h00;
            for (int k = 0; k < 8; k++) begin
                step(100);
                got[k] = midi_out;
            end
            chk($sformatf("%s_b%0d_value", tag, b), got, exp_b[b]);
            step(100);
            chk($sformatf("%s_b%0d_stop", tag, b), {7'd0, midi_out}, 8'd1);
            chk($sformatf("%s_b%0d_done_early", tag, b), {7'd0, byte_done}, 8'd0);
            step(49);
            chk($sformatf("%s_b%0d_byte_done", tag, b), {7'd0, byte_done}, 8'd1);
            if (b == n - 1) begin
                chk($sformatf("%s_busy_end", tag), {7'd0, busy}, 8'd0);
                chk($sformatf("%s_ready_end", tag), {7'd0, msg_ready}, 8'd1);
            end else begin
                chk($sformatf("%s_b%0d_busy_mid", tag, b), {7'd0, busy}, 8'd1);
            end
        end
        step(1);
        chk({tag, "_line_idle_after"}, {7'd0, midi_out}, 8'd1);
        chk({tag, "_done_one_cycle"}, {7'd0, byte_done}, 8'd0);
    endtask

    initial begin
        reset      = 1'b0;
        msg_valid  = 1'b0;
        msg_status = 8'h00;
        msg_data1  = 8'h00;
        msg_data2  = 8'h00;
        msg_len    = 2'd0;

        // Reset state while reset is asserted
        #12;
        chk("rst_line", {7'd0, midi_out}, 8'd1);
        chk("rst_ready", {7'd0, msg_ready}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_byte_done", {7'd0, byte_done}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1);
        chk("post_rst_ready", {7'd0, msg_ready}, 8'd1);
        chk("post_rst_line", {7'd0, midi_out}, 8'd1);
        chk("post_rst_busy", {7'd0, busy}, 8'd0);

        // Full note-on
        send(8'h90, 8'h3C, 8'h64, 2'd3);
        msg_valid = 1'b0;
        frames("noteon", 3, 8'h90, 8'h3C, 8'h64);

        // Single real-time byte
        send(8'hF8, 8'h00, 8'h00, 2'd1);
        msg_valid = 1'b0;
        frames("clock", 1, 8'hF8, 8'h00, 8'h00);
        chk("clock_ready_1001", {7'd0, msg_ready}, 8'd1);

        // Length 0 behaves as length 1
        send(8'hFE, 8'h11, 8'h22, 2'd0);
        msg_valid = 1'b0;
        frames("len0", 1, 8'hFE, 8'h00, 8'h00);

        // System common clears running status
        send(8'hF2, 8'h10, 8'h00, 2'd3);
        msg_valid = 1'b0;
        frames("songpos", 3, 8'hF2, 8'h10, 8'h00);

        // Two queued note-ons with valid held high
        send(8'h90, 8'h3C, 8'h64, 2'd3);
        msg_status = 8'h90;
        msg_data1  = 8'h3E;
        msg_data2  = 8'h64;
        msg_len    = 2'd3;
        frames("queued_a", 3, 8'h90, 8'h3C, 8'h64);
        msg_valid = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        frames("queued_b", 2, 8'h3E, 8'h64, 8'h00);
`else
        frames("queued_b", 3, 8'h90, 8'h3E, 8'h64);
`endif

        // Repeated status with length 1 is always sent
        send(8'h90, 8'h00, 8'h00, 2'd1);
        msg_valid = 1'b0;
        frames("rs_len1", 1, 8'h90, 8'h00, 8'h00);

        // Two-byte message with repeated status
        send(8'h90, 8'h45, 8'h77, 2'd2);
        msg_valid = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        frames("rs_len2", 1, 8'h45, 8'h00, 8'h00);
`else
        frames("rs_len2", 2, 8'h90, 8'h45, 8'h00);
`endif

        // Real-time byte does not disturb running status
        send(8'hF8, 8'h00, 8'h00, 2'd1);
        msg_valid = 1'b0;
        frames("rt_mid", 1, 8'hF8, 8'h00, 8'h00);
        send(8'h90, 8'h46, 8'h64, 2'd3);
        msg_valid = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
        frames("rs_after_rt", 2, 8'h46, 8'h64, 8'h00);
`else
        frames("rs_after_rt", 3, 8'h90, 8'h46, 8'h64);
`endif

        // 0xF2 between note-ons forces the status to be resent
        send(8'hF2, 8'h00, 8'h00, 2'd3);
        msg_valid = 1'b0;
        frames("f2_clear", 3, 8'hF2, 8'h00, 8'h00);
        send(8'h90, 8'h41, 8'h64, 2'd3);
        msg_valid = 1'b0;
        frames("resend_status", 3, 8'h90, 8'h41, 8'h64);

        // Reset during bit 4 of the second byte (0x07: bit 4 is 0)
        send(8'hB0, 8'h07, 8'h40, 2'd3);
        msg_valid = 1'b0;
        step(1550);
        chk("abort_bit4_before", {7'd0, midi_out}, 8'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_line_async", {7'd0, midi_out}, 8'd1);
        chk("abort_ready_in_rst", {7'd0, msg_ready}, 8'd0);
        chk("abort_busy_in_rst", {7'd0, busy}, 8'd0);
        step(3);
        chk("abort_line_held", {7'd0, midi_out}, 8'd1);
        reset = 1'b1;
        #1;
        chk("abort_ready_release", {7'd0, msg_ready}, 8'd1);
        step(300);
        chk("abort_no_resume_line", {7'd0, midi_out}, 8'd1);
        chk("abort_no_resume_busy", {7'd0, busy}, 8'd0);
        send(8'h80, 8'h40, 8'h00, 2'd3);
        msg_valid = 1'b0;
        frames("after_abort", 3, 8'h80, 8'h40, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_tx.md
# midi_tx

MIDI output transmitter: the send-side counterpart of the synth's MIDI input port. Accepts one complete MIDI message (1–3 bytes) per valid/ready handshake and serializes it on a single wire as 8N1 UART frames at the MIDI rate (31250 baud), LSB first. Sits beside `midi_synth` under the top level and drives a MIDI OUT/THRU pin for note echo, controller feedback or sequencing.

## Interface
- `CLK_HZ`, 48_000_000: frequency of `clk` in Hz (PLL output).
- `BAUD`, 31250: line rate. `CLKS_PER_BIT = CLK_HZ / BAUD`, truncated; must be ≥ 4.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `msg_valid` input 1: a message is presented on `msg_status`/`msg_data1`/`msg_data2`/`msg_len`.
- `msg_ready` output 1: block can accept a message. A message transfers on the rising edge where `msg_valid && msg_ready`.
- `msg_status` input 8: status byte (bit 7 set by the producer; not checked).
- `msg_data1` input 8: first data byte, sent if `msg_len` ≥ 2.
- `msg_data2` input 8: second data byte, sent if `msg_len` = 3.
- `msg_len` input 2: total bytes in the message: 1, 2 or 3. Value 0 is treated as 1.
- `midi_out` output 1: serial line; idle high.
- `busy` output 1: high from acceptance until the last stop bit completes.
- `byte_done` output 1: one-cycle pulse at the end of each transmitted byte's stop bit.

## Operation
- On acceptance, all message fields and the effective byte count are registered. Inputs are don't-care afterward.
- The byte sequence is the status byte (unless suppressed, see Configuration), then data1, then data2, truncated to the effective length.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `midi_out`=1 and `msg_ready`=1. On handshake, load the first byte and go to START.
  - START: `midi_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `midi_out`=shift[0] for `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `midi_out`=1 for `CLKS_PER_BIT` cycles. On the final cycle, pulse `byte_done`. If bytes remain, load the next byte and go to START. Otherwise go to IDLE.
- Consecutive bytes of one message are sent back-to-back, with no idle time between frames.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index: 3 bits.
  - Remaining-byte counter: 2 bits.
- Reset values: `midi_out`=1, `msg_ready`=0 while reset is asserted and 1 in the first cycle after release (state IDLE), `busy`=0, `byte_done`=0, counters 0, running-status register cleared.
- Reset mid-frame: the frame is abandoned immediately (asynchronously), `midi_out` returns high, and the remaining message is discarded. No partial byte is resumed.

## Timing
- Latency: `midi_out` falls (start bit) on the first rising edge after the accepting edge.
- A byte frame lasts exactly 10 × `CLKS_PER_BIT` cycles. A message of N transmitted bytes lasts N × 10 × `CLKS_PER_BIT` cycles.
- `msg_ready` is low from the cycle after acceptance until the cycle after the last stop bit ends. The earliest next start bit is therefore one cycle after the previous stop bit.
- `busy` = !`msg_ready` outside reset.
- Only one message is in flight; the block has no input buffering.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - A 1-bit "valid" flag and an 8-bit last-status register track running status.
  - A message with `msg_status` in 0x80–0xEF that equals the stored status (flag set) omits its status byte, and its effective length drops by 1.
  - A message with `msg_len`=1 and a repeated status is still sent in full.
  - Status 0x80–0xEF stores the status and sets the flag.
  - Status 0xF0–0xF7 clears the flag.
  - Status 0xF8–0xFF leaves the flag unchanged.
  - The update takes place at acceptance.
- Undefined: every message sends its status byte, and no running-status logic is present.

## Test plan
- Use `CLK_HZ`=3_125_000, `BAUD`=31250 (100 clks/bit) for all scenarios.
- After reset, `midi_out`=1 and `msg_ready`=1. Send 0x90/0x3C/0x64 with len 3 → the line decodes to bytes 0x90, 0x3C, 0x64, the start bit begins 1 cycle after the handshake, `busy` stays high for 3000 cycles, and `byte_done` pulses 3 times at cycles 1000, 2000 and 3000.
- Send 0xF8 with len 1 → one frame (0,0,0,0,1,1,1,1,1,1 on the line, LSB first) lasting 1000 cycles, and `msg_ready` is high at cycle 1001.
- Send len 0 with status 0xFE → identical to len 1: a single 0xFE frame.
- With `msg_valid` held high and two queued note-ons (0x90 3C 64, 0x90 3E 64):
  - With `MIDI_RUNNING_STATUS_EN` defined → the second message sends only 3E 64 (2000 cycles).
  - Without the macro → the second message is 3000 cycles.
  - With the macro, inserting 0xF2 between the two note-ons → the second note-on resends 0x90.
- Assert `reset` low during bit 4 of the second byte → `midi_out`=1 within the same cycle, and after release the block is IDLE with `msg_ready`=1. A subsequent 0x80 40 00 message is sent in full, including the status byte.
